// File: rtl/stream_req_arbiter.sv
// Round-robin arbiter that hands the shared weight/activation read port to one PE
// controller at a time and walks its filter slice and input tile beat by beat.
module stream_req_arbiter #(
   parameter int NUM_PE = 4,
   parameter int K_W    = 6,
   parameter int L_W    = 3,
   parameter int LEN_W  = 12,
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PE-1:0]       req_filter_valid,
   input  logic [NUM_PE-1:0]       req_input_valid,
   input  logic [NUM_PE*K_W-1:0]   req_k,
   input  logic [NUM_PE*L_W-1:0]   req_layer,
   input  logic [LEN_W-1:0]        cfg_filter_len,
   input  logic [LEN_W-1:0]        cfg_input_len,
   input  logic [ADDR_W-1:0]       cfg_filter_base,
   input  logic [ADDR_W-1:0]       cfg_input_base,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [ADDR_W-1:0]       rd_addr,
   output logic                    rd_is_input,
   output logic [L_W-1:0]          rd_layer,
   output logic [NUM_PE-1:0]       rd_pe,
   output logic [NUM_PE-1:0]       filter_finish,
   output logic [NUM_PE-1:0]       input_finish,
   output logic                    busy
);

   localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int FW    = K_W + LEN_W + ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILTER = 2'd1,
      ST_INPUT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [PTR_W-1:0]  rr_ptr_r, rr_ptr_s;
   logic [NUM_PE-1:0] mask_r, mask_s, grant_r, grant_s;
   logic [LEN_W-1:0]  beat_r, beat_s, flen_r, flen_s, ilen_r, ilen_s;
   logic [ADDR_W-1:0] fbase_r, fbase_s, ibase_r, ibase_s;
   logic [L_W-1:0]    layer_r, layer_s;
   logic              in_req_r, in_req_s;

   logic              accept_s;
   logic [NUM_PE-1:0] elig_s;
   logic              found_s;
   logic [PTR_W-1:0]  win_s, idx_s;
   logic [K_W-1:0]    sel_k_s;
   logic [FW-1:0]     fbase_full_s;

   logic              rd_valid_s, rd_is_input_s, busy_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [L_W-1:0]    rd_layer_s;
   logic [NUM_PE-1:0] rd_pe_s, filter_finish_s, input_finish_s;

   assign accept_s = rd_valid & rd_ready;

   // Round-robin search for the first unmasked requester starting at rr_ptr.
   always_comb begin
      elig_s  = req_filter_valid & ~mask_r;
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         idx_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_PE);
         if (!found_s && elig_s[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            win_s = win_s;
         end
      end
      sel_k_s      = req_k[win_s*K_W +: K_W];
      fbase_full_s = FW'(cfg_filter_base) + FW'(sel_k_s) * FW'(cfg_filter_len);
   end

   // Next-state and next-context logic.
   always_comb begin
      state_s  = state_r;
      rr_ptr_s = rr_ptr_r;
      mask_s   = mask_r;
      grant_s  = grant_r;
      beat_s   = beat_r;
      flen_s   = flen_r;
      ilen_s   = ilen_r;
      fbase_s  = fbase_r;
      ibase_s  = ibase_r;
      layer_s  = layer_r;
      in_req_s = in_req_r;
      case (state_r)
         ST_IDLE: begin
            mask_s = '0;
            if (found_s) begin
               grant_s  = NUM_PE'(1) << win_s;
               layer_s  = req_layer[win_s*L_W +: L_W];
               in_req_s = req_input_valid[win_s];
               flen_s   = cfg_filter_len;
               ilen_s   = cfg_input_len;
               fbase_s  = fbase_full_s[ADDR_W-1:0];
               ibase_s  = cfg_input_base;
               beat_s   = '0;
               if (int'(win_s) == NUM_PE - 1) begin
                  rr_ptr_s = '0;
               end else begin
                  rr_ptr_s = win_s + PTR_W'(1);
               end
               if (cfg_filter_len != '0) begin
                  state_s = ST_FILTER;
               end else if (req_input_valid[win_s] && cfg_input_len != '0) begin
                  state_s = ST_INPUT;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FILTER: begin
            if (accept_s && beat_r == flen_r - LEN_W'(1)) begin
               beat_s  = '0;
               state_s = (in_req_r && ilen_r != '0) ? ST_INPUT : ST_DONE;
            end else if (accept_s) begin
               beat_s = beat_r + LEN_W'(1);
            end else begin
               beat_s = beat_r;
            end
         end
         ST_INPUT: begin
            if (accept_s && beat_r == ilen_r - LEN_W'(1)) begin
               beat_s  = '0;
               state_s = ST_DONE;
            end else if (accept_s) begin
               beat_s = beat_r + LEN_W'(1);
            end else begin
               beat_s = beat_r;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            mask_s  = grant_r;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so they can be registered.
   always_comb begin
      rd_valid_s      = (state_s == ST_FILTER) || (state_s == ST_INPUT);
      rd_is_input_s   = (state_s == ST_INPUT);
      busy_s          = (state_s != ST_IDLE);
      rd_layer_s      = busy_s ? layer_s : '0;
      rd_pe_s         = busy_s ? grant_s : '0;
      filter_finish_s = (state_s == ST_DONE) ? grant_s : '0;
      input_finish_s  = (state_s == ST_DONE && in_req_s) ? grant_s : '0;
      case (state_s)
         ST_FILTER: rd_addr_s = fbase_s + ADDR_W'(beat_s);
         ST_INPUT:  rd_addr_s = ibase_s + ADDR_W'(beat_s);
         default:   rd_addr_s = '0;
      endcase
   end

   // State, arbitration and burst context registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         rr_ptr_r <= '0;
         mask_r   <= '0;
         grant_r  <= '0;
         beat_r   <= '0;
         flen_r   <= '0;
         ilen_r   <= '0;
         fbase_r  <= '0;
         ibase_r  <= '0;
         layer_r  <= '0;
         in_req_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         rr_ptr_r <= rr_ptr_s;
         mask_r   <= mask_s;
         grant_r  <= grant_s;
         beat_r   <= beat_s;
         flen_r   <= flen_s;
         ilen_r   <= ilen_s;
         fbase_r  <= fbase_s;
         ibase_r  <= ibase_s;
         layer_r  <= layer_s;
         in_req_r <= in_req_s;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid      <= 1'b0;
         rd_addr       <= '0;
         rd_is_input   <= 1'b0;
         rd_layer      <= '0;
         rd_pe         <= '0;
         filter_finish <= '0;
         input_finish  <= '0;
         busy          <= 1'b0;
      end else begin
         rd_valid      <= rd_valid_s;
         rd_addr       <= rd_addr_s;
         rd_is_input   <= rd_is_input_s;
         rd_layer      <= rd_layer_s;
         rd_pe         <= rd_pe_s;
         filter_finish <= filter_finish_s;
         input_finish  <= input_finish_s;
         busy          <= busy_s;
      end
   end

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Directed bench for stream_req_arbiter with hand-computed addresses, grant order and finish pulses.
module tb_stream_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_filter_valid, req_input_valid;
   logic [23:0] req_k;
   logic [11:0] req_layer;
   logic [11:0] cfg_filter_len, cfg_input_len;
   logic [15:0] cfg_filter_base, cfg_input_base;
   logic        rd_valid, rd_ready, rd_is_input, busy;
   logic [15:0] rd_addr;
   logic [2:0]  rd_layer;
   logic [3:0]  rd_pe, filter_finish, input_finish;

   int errors = 0;
   int checks = 0;

   stream_req_arbiter #(.NUM_PE(4), .K_W(6), .L_W(3), .LEN_W(12), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_filter_valid(req_filter_valid), .req_input_valid(req_input_valid),
      .req_k(req_k), .req_layer(req_layer),
      .cfg_filter_len(cfg_filter_len), .cfg_input_len(cfg_input_len),
      .cfg_filter_base(cfg_filter_base), .cfg_input_base(cfg_input_base),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_is_input(rd_is_input), .rd_layer(rd_layer), .rd_pe(rd_pe),
      .filter_finish(filter_finish), .input_finish(input_finish), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int acc, nvalid, done;

   initial begin
      rst = 1'b1;
      req_filter_valid = '0; req_input_valid = '0; req_k = '0; req_layer = '0;
      cfg_filter_len = '0; cfg_input_len = '0; cfg_filter_base = '0; cfg_input_base = '0;
      rd_ready = 1'b1;
      tick(); tick();
      check("rst_valid", 32'(rd_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pe", 32'(rd_pe), 32'd0);
      check("rst_ff", 32'(filter_finish), 32'd0);
      check("rst_addr", 32'(rd_addr), 32'd0);
      rst = 1'b0;

      // PE0 filter only: k=2, flen=4, base 0x100 -> 0x108..0x10B
      cfg_filter_len = 12'd4; cfg_filter_base = 16'h0100;
      req_k[0 +: 6] = 6'd2; req_layer[0 +: 3] = 3'd1; req_filter_valid = 4'b0001;
      tick();
      for (int b = 0; b < 4; b++) begin
         check("t1_valid", 32'(rd_valid), 32'd1);
         check("t1_addr", 32'(rd_addr), 32'h108 + 32'(b));
         check("t1_ff_low", 32'(filter_finish), 32'd0);
         tick();
      end
      check("t1_done_valid", 32'(rd_valid), 32'd0);
      check("t1_ff", 32'(filter_finish), 32'b0001);
      check("t1_if", 32'(input_finish), 32'd0);
      req_filter_valid = '0;
      tick();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_ff", 32'(filter_finish), 32'd0);

      // PE1 filter+input: k=0, flen=2, ilen=3, input base 0x800
      cfg_filter_base = 16'h0000; cfg_filter_len = 12'd2; cfg_input_len = 12'd3; cfg_input_base = 16'h0800;
      req_k[6 +: 6] = 6'd0; req_layer[3 +: 3] = 3'd5;
      req_filter_valid = 4'b0010; req_input_valid = 4'b0010;
      tick();
      check("t2_pe", 32'(rd_pe), 32'b0010);
      check("t2_layer", 32'(rd_layer), 32'd5);
      for (int b = 0; b < 2; b++) begin
         check("t2_faddr", 32'(rd_addr), 32'(b));
         check("t2_fin", 32'(rd_is_input), 32'd0);
         tick();
      end
      for (int b = 0; b < 3; b++) begin
         check("t2_iaddr", 32'(rd_addr), 32'h800 + 32'(b));
         check("t2_iin", 32'(rd_is_input), 32'd1);
         tick();
      end
      check("t2_ff", 32'(filter_finish), 32'b0010);
      check("t2_if", 32'(input_finish), 32'b0010);
      req_filter_valid = '0; req_input_valid = '0;
      tick();
      check("t2_idle_busy", 32'(busy), 32'd0);

      // All four PEs requesting, flen=1, base 0x200, k=i -> order 0,1,2,3,0
      rst = 1'b1; tick(); rst = 1'b0;
      cfg_filter_len = 12'd1; cfg_input_len = 12'd0; cfg_filter_base = 16'h0200;
      for (int i = 0; i < 4; i++) req_k[i*6 +: 6] = 6'(i);
      req_filter_valid = 4'b1111;
      tick();
      for (int g = 0; g < 5; g++) begin
         check("t3_pe", 32'(rd_pe), 32'd1 << (g % 4));
         check("t3_addr", 32'(rd_addr), 32'h200 + 32'(g % 4));
         tick();
         check("t3_ff", 32'(filter_finish), 32'd1 << (g % 4));
         tick();
         check("t3_idle", 32'(busy), 32'd0);
         tick();
      end
      req_filter_valid = '0;
      tick(); tick();

      // Single PE2 holding its request: masked for one IDLE cycle after DONE
      req_filter_valid = 4'b0100;
      tick();
      check("t3m_pe", 32'(rd_pe), 32'b0100);
      tick();
      check("t3m_ff", 32'(filter_finish), 32'b0100);
      tick();
      check("t3m_idle1", 32'(busy), 32'd0);
      tick();
      check("t3m_masked", 32'(rd_valid), 32'd0);
      tick();
      check("t3m_regrant", 32'(rd_pe), 32'b0100);
      req_filter_valid = '0;
      tick(); tick();

      // PE3 3-beat burst with rd_ready 1,0,0,1,0,0,1: k=1, base 0x300 -> 0x303..0x305
      cfg_filter_len = 12'd3; cfg_filter_base = 16'h0300; req_k[18 +: 6] = 6'd1;
      req_filter_valid = 4'b1000;
      tick();
      acc = 0; nvalid = 0; done = 0;
      for (int c = 0; c < 16 && done == 0; c++) begin
         if (filter_finish == 4'b1000) begin
            done = 1;
         end else begin
            if (rd_valid) begin
               check("t4_addr", 32'(rd_addr), 32'h303 + 32'(acc));
               rd_ready = (nvalid % 3 == 0);
               if (rd_ready) acc++;
               nvalid++;
            end
            tick();
         end
      end
      check("t4_finished", 32'(done), 32'd1);
      check("t4_valid_cycles", 32'(nvalid), 32'd7);
      rd_ready = 1'b1;
      req_filter_valid = '0;
      tick();

      // PE0 with flen=0, ilen=0 and input request: IDLE -> DONE -> IDLE
      cfg_filter_len = 12'd0; cfg_input_len = 12'd0;
      req_filter_valid = 4'b0001; req_input_valid = 4'b0001;
      tick();
      check("t5_valid", 32'(rd_valid), 32'd0);
      check("t5_ff", 32'(filter_finish), 32'b0001);
      check("t5_if", 32'(input_finish), 32'b0001);
      check("t5_busy", 32'(busy), 32'd1);
      req_filter_valid = '0; req_input_valid = '0;
      tick();
      check("t5_idle_valid", 32'(rd_valid), 32'd0);
      check("t5_idle_ff", 32'(filter_finish), 32'd0);

      // PE1 4-beat burst, reset on beat 2, then re-request with PE1 and PE3
      cfg_filter_len = 12'd4; cfg_filter_base = 16'h0100; req_k[6 +: 6] = 6'd0;
      req_filter_valid = 4'b0010;
      tick(); tick(); tick();
      check("t6_beat2", 32'(rd_addr), 32'h102);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", 32'(rd_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_pe", 32'(rd_pe), 32'd0);
      check("t6_rst_addr", 32'(rd_addr), 32'd0);
      check("t6_rst_ff", 32'(filter_finish), 32'd0);
      rst = 1'b0;
      req_filter_valid = 4'b1010;
      tick();
      check("t6_restart_pe", 32'(rd_pe), 32'b0010);
      check("t6_restart_addr", 32'(rd_addr), 32'h100);
      req_filter_valid = '0;
      tick(); tick(); tick();
      check("t6_last_addr", 32'(rd_addr), 32'h103);
      tick();
      check("t6_ff", 32'(filter_finish), 32'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
